// File: rtl/btn_led_pwm_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module   : btn_led_pwm_ctrl_pkg
// Brief    : Shared button indices and brightness duty computation.
// Revision : 1.0 - initial release
//============================================================================
package btn_led_pwm_ctrl_pkg;

    localparam int N_BTN   = 4;
    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_UP  = 2;
    localparam int BTN_DN  = 3;

    // Levels at or above the top level clamp to full period (constant on).
    function automatic int calc_duty(input int lvl, input int n_level, input int period);
        if (lvl >= n_level - 1)
            return period;
        else if (lvl == 0)
            return period / 20;
        else
            return (period * lvl) / (n_level - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_led_pwm_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : btn_led_pwm_ctrl_if
// Brief    : Button inputs and LED/count/level outputs of the controller.
// Revision : 1.0 - initial release
//============================================================================
interface btn_led_pwm_ctrl_if
    import btn_led_pwm_ctrl_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int LVL_W = 3
);
    logic [N_BTN-1:0] usr_btn;
    logic [N_LED-1:0] usr_led;
    logic [N_LED-1:0] count;
    logic [LVL_W-1:0] level;

    modport master (output usr_btn, input usr_led, input count, input level);
    modport slave  (input usr_btn, output usr_led, output count, output level);
endinterface
`default_nettype wire

// File: rtl/btn_led_pwm_ctrl_debounce.sv
`default_nettype none
//============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchronizer, stability debouncer and press-edge pulse.
// Revision : 1.0 - initial release
//============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_press
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_deb_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_deb_d <= r_deb;
            // Count only consecutive cycles that disagree with the output.
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                r_deb <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_deb;
    assign o_press = r_deb & ~r_deb_d;

endmodule
`default_nettype wire

// File: rtl/btn_led_pwm_ctrl.sv
`default_nettype none
//============================================================================
// Module   : btn_led_pwm_ctrl
// Brief    : Debounced step counter and brightness level driving PWM LEDs.
// Revision : 1.0 - initial release
//============================================================================
module btn_led_pwm_ctrl
    import btn_led_pwm_ctrl_pkg::*;
#(
    parameter int N_LED        = 4,
    parameter int N_LEVEL      = 5,
    parameter int DEB_CYCLES   = 1000000,
    parameter int PWM_PERIOD   = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int WRAP         = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    btn_led_pwm_ctrl_if.slave ctrl_if
);
    localparam int LVL_W   = $clog2(N_LEVEL);
    localparam int DUTY_W  = $clog2(PWM_PERIOD + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [N_LED-1:0] c_cnt_max = {1'b0, {(N_LED-1){1'b1}}};
    localparam logic [N_LED-1:0] c_cnt_min = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [LVL_W-1:0] c_lvl_top = LVL_W'(N_LEVEL - 1);

    logic [N_BTN-1:0]  w_evt;
    logic [N_LED-1:0]  r_count;
    logic [LVL_W-1:0]  r_level;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [N_LED-1:0]  r_led;
    logic [DUTY_W-1:0] w_duty_tab [2**LVL_W];
    logic              w_pwm_on;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        localparam bit RPT_EN = (gi == BTN_INC) || (gi == BTN_DEC);

        logic             w_lvl;
        logic             w_press;
        logic             w_tick;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_phase;

        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (ctrl_if.usr_btn[gi]),
            .o_level (w_lvl),
            .o_press (w_press)
        );

        // Phase 0 waits REPEAT_DELAY after the press, phase 1 ticks every REPEAT_RATE.
        assign w_tick = RPT_EN && w_lvl &&
                        (r_rpt_cnt == (r_rpt_phase ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY)));

        always_ff @(posedge clk) begin
            if (reset || !w_lvl) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b0;
            end else if (w_press) begin
                r_rpt_cnt   <= RPT_W'(1);
                r_rpt_phase <= 1'b0;
            end else if (w_tick) begin
                r_rpt_cnt   <= RPT_W'(1);
                r_rpt_phase <= 1'b1;
            end else if (r_rpt_cnt != '0) begin
                r_rpt_cnt   <= r_rpt_cnt + 1'b1;
            end
        end

        assign w_evt[gi] = w_press | w_tick;
    end

    for (genvar gl = 0; gl < 2**LVL_W; gl++) begin : g_duty
        assign w_duty_tab[gl] = DUTY_W'(calc_duty(gl, N_LEVEL, PWM_PERIOD));
    end

    assign w_pwm_on = (r_pwm_cnt < w_duty_tab[r_level]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_level   <= c_lvl_top;
            r_pwm_cnt <= '0;
            r_led     <= '0;
        end else begin
            if (w_evt[BTN_INC] && !w_evt[BTN_DEC]) begin
                if (WRAP != 0 || r_count != c_cnt_max)
                    r_count <= r_count + 1'b1;
            end else if (w_evt[BTN_DEC] && !w_evt[BTN_INC]) begin
                if (WRAP != 0 || r_count != c_cnt_min)
                    r_count <= r_count - 1'b1;
            end

            if (w_evt[BTN_UP] && !w_evt[BTN_DN]) begin
                if (r_level != c_lvl_top)
                    r_level <= r_level + 1'b1;
            end else if (w_evt[BTN_DN] && !w_evt[BTN_UP]) begin
                if (r_level != '0)
                    r_level <= r_level - 1'b1;
            end

            r_pwm_cnt <= (r_pwm_cnt == DUTY_W'(PWM_PERIOD - 1)) ? '0 : r_pwm_cnt + 1'b1;
            r_led     <= r_count & {N_LED{w_pwm_on}};
        end
    end

    assign ctrl_if.count   = r_count;
    assign ctrl_if.level   = r_level;
    assign ctrl_if.usr_led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_btn_led_pwm_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_btn_led_pwm_ctrl
// Brief    : Directed self-checking bench for btn_led_pwm_ctrl.
// Revision : 1.0 - initial release
//============================================================================
module tb_btn_led_pwm_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ones;

    always #5 clk = ~clk;

    btn_led_pwm_ctrl_if #(.N_LED(4), .LVL_W(3)) ifa ();
    btn_led_pwm_ctrl_if #(.N_LED(4), .LVL_W(3)) ifb ();

    btn_led_pwm_ctrl #(
        .N_LED(4), .N_LEVEL(5), .DEB_CYCLES(4), .PWM_PERIOD(20),
        .REPEAT_DELAY(50), .REPEAT_RATE(10), .WRAP(0)
    ) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (ifa.slave)
    );

    btn_led_pwm_ctrl #(
        .N_LED(4), .N_LEVEL(5), .DEB_CYCLES(4), .PWM_PERIOD(20),
        .REPEAT_DELAY(50), .REPEAT_RATE(10), .WRAP(1)
    ) dut_wrap (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (ifb.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_a(input logic [3:0] b);
        ifa.usr_btn = b;
        tick(10);
        ifa.usr_btn = 4'b0000;
        tick(10);
    endtask

    task automatic press_b(input logic [3:0] b);
        ifb.usr_btn = b;
        tick(10);
        ifb.usr_btn = 4'b0000;
        tick(10);
    endtask

    task automatic measure(output int n);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += $countones(ifa.usr_led);
        end
    endtask

    initial begin
        ifa.usr_btn = 4'b0000;
        ifb.usr_btn = 4'b0000;
        reset = 1'b1;
        tick(3);
        check("rst_count", ifa.count, 4'h0);
        check("rst_level", ifa.level, 3'd4);
        check("rst_led", ifa.usr_led, 4'h0);
        check("rst_count_wrap", ifb.count, 4'h0);
        reset = 1'b0;

        // Bounce on btn0, then a clean hold with exact press latency.
        for (int i = 0; i < 10; i++) begin
            ifa.usr_btn[0] = ~ifa.usr_btn[0];
            tick(2);
        end
        check("bounce_quiet", ifa.count, 4'h0);
        ifa.usr_btn[0] = 1'b1;
        tick(6);
        check("press_latency_pre", ifa.count, 4'h0);
        tick(1);
        check("press_latency", ifa.count, 4'h1);
        tick(3);
        ifa.usr_btn = 4'b0000;
        tick(10);
        check("bounce_one_inc", ifa.count, 4'h1);

        // Saturation at +7 and -8.
        for (int i = 0; i < 6; i++) press_a(4'b0001);
        check("sat_reach_7", ifa.count, 4'h7);
        for (int i = 0; i < 4; i++) press_a(4'b0001);
        check("sat_hold_7", ifa.count, 4'h7);
        for (int i = 0; i < 20; i++) press_a(4'b0010);
        check("sat_hold_m8", ifa.count, 4'h8);

        // Auto-repeat: events at offsets 0, 50, 60, 70, 80 after the press.
        ifa.usr_btn = 4'b0001;
        tick(7);
        check("rpt_off0", ifa.count, 4'h9);
        tick(49);
        check("rpt_before50", ifa.count, 4'h9);
        tick(1);
        check("rpt_off50", ifa.count, 4'hA);
        tick(9);
        check("rpt_before60", ifa.count, 4'hA);
        tick(1);
        check("rpt_off60", ifa.count, 4'hB);
        tick(10);
        check("rpt_off70", ifa.count, 4'hC);
        tick(10);
        check("rpt_off80", ifa.count, 4'hD);
        ifa.usr_btn = 4'b0000;
        tick(30);
        check("rpt_after_release", ifa.count, 4'hD);

        // PWM duty per level with all LEDs enabled by count = 4'b1111.
        press_a(4'b0001);
        press_a(4'b0001);
        check("pwm_count_all", ifa.count, 4'hF);
        measure(ones);
        check("duty_l4", ones, 80);
        press_a(4'b1000);
        check("level_3", ifa.level, 3'd3);
        measure(ones);
        check("duty_l3", ones, 60);
        press_a(4'b1000);
        measure(ones);
        check("duty_l2", ones, 40);
        press_a(4'b1000);
        measure(ones);
        check("duty_l1", ones, 20);
        press_a(4'b1000);
        check("level_0", ifa.level, 3'd0);
        measure(ones);
        check("duty_l0", ones, 4);
        press_a(4'b1000);
        check("level_sat_0", ifa.level, 3'd0);

        // Simultaneous events and upper level saturation.
        press_a(4'b0100);
        press_a(4'b0100);
        check("level_2", ifa.level, 3'd2);
        press_a(4'b1100);
        check("level_simul", ifa.level, 3'd2);
        press_a(4'b0011);
        check("count_simul", ifa.count, 4'hF);
        press_a(4'b0100);
        press_a(4'b0100);
        press_a(4'b0100);
        check("level_sat_top", ifa.level, 3'd4);

        // Reset two cycles into a debounce discards the press.
        ifa.usr_btn = 4'b0001;
        tick(2);
        reset = 1'b1;
        ifa.usr_btn = 4'b0000;
        tick(2);
        check("mid_rst_led", ifa.usr_led, 4'h0);
        reset = 1'b0;
        tick(20);
        check("mid_rst_count", ifa.count, 4'h0);
        check("mid_rst_level", ifa.level, 3'd4);

        // Button held across reset needs a full debounce afterwards.
        ifa.usr_btn = 4'b0001;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("held_rst_pre", ifa.count, 4'h0);
        tick(1);
        check("held_rst_inc", ifa.count, 4'h1);
        ifa.usr_btn = 4'b0000;
        tick(20);

        // Wrapping counter.
        for (int i = 0; i < 7; i++) press_b(4'b0001);
        check("wrap_reach_7", ifb.count, 4'h7);
        press_b(4'b0001);
        check("wrap_to_m8", ifb.count, 4'h8);
        press_b(4'b0010);
        check("wrap_back_7", ifb.count, 4'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
